uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the received character width.
REQ-002 The block SHALL have parameter DEPTH, default 16 (power of 2, >=2), meaning the number of FIFO entries.
REQ-003 The block SHALL have parameter THRESH, default 8 (1..DEPTH), meaning the fill level that asserts thresh_irq.
REQ-004 The block SHALL have parameter TIMEOUT_TICKS, default 704 (4 characters x 11 bits x 16), meaning the idle baud_en_16x ticks before timeout_irq asserts.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 baud_en_16x  in  1  single-cycle 16x baud tick, shared with the receiver.
REQ-008 rx_data  in  DATA_WIDTH  character from the receiver, valid when rx_ready=1.
REQ-009 rx_ready  in  1  single-cycle strobe; the character is valid.
REQ-010 rx_error  in  1  with rx_ready=1 it is a parity error on that character; without rx_ready it is a framing error with no character.
REQ-011 rd_en  in  1  pop request from the bus side.
REQ-012 flush  in  1  synchronous FIFO clear.
REQ-013 clr_status  in  1  clears the sticky overrun and frame_err flags.
REQ-014 rd_data  out  DATA_WIDTH  head entry data, first-word fall-through.
REQ-015 rd_perr  out  1  parity-error flag stored with the head entry.
REQ-016 empty, full  out  1 each  FIFO status.
REQ-017 level  out  $clog2(DEPTH)+1  number of entries held, 0..DEPTH.
REQ-018 overrun, frame_err  out  1 each  sticky error flags.
REQ-019 thresh_irq, timeout_irq  out  1 each  interrupt requests.

Function
REQ-020 Push: rx_ready=1 SHALL write {rx_error, rx_data} at the write pointer; the entry becomes visible on rd_data/rd_perr the next cycle.
REQ-021 Pop: rd_en=1 with empty=0 SHALL advance the read pointer; rd_data SHALL show the new head the next cycle; rd_en with empty=1 SHALL be ignored with no pointer or level change.
REQ-022 rd_data and rd_perr SHALL always reflect the head entry when empty=0; their values when empty=1 are don't-care.
REQ-023 Push with full=1 and no pop SHALL drop the character, leave FIFO contents unchanged, and set overrun.
REQ-024 Simultaneous push and pop with full=1 SHALL perform both, with level staying at DEPTH and overrun unchanged.
REQ-025 Simultaneous push and pop with empty=1 SHALL perform the push only, giving level=1.
REQ-026 Simultaneous push and pop otherwise SHALL keep level unchanged.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0; full and empty SHALL be derived without ambiguity using extra-bit pointers or the level count.
REQ-028 rx_error=1 with rx_ready=0 SHALL set frame_err and SHALL NOT push.
REQ-029 overrun and frame_err SHALL stay set until clr_status or flush; a set event in the same cycle as clr_status SHALL win.
REQ-030 flush SHALL reset the pointers and level to 0 and clear overrun, frame_err, timeout_irq and the timeout counter; flush SHALL take priority over a push or pop in the same cycle, which are discarded.
REQ-031 thresh_irq SHALL equal (level >= THRESH), registered with level and with no extra latency.
REQ-032 The timeout counter SHALL reset to 0 on any push, any successful pop, or while empty=1, and SHALL otherwise increment on each baud_en_16x, saturating at TIMEOUT_TICKS.
REQ-033 timeout_irq SHALL be set the cycle after the counter reaches TIMEOUT_TICKS and SHALL be cleared by a successful pop, a push, or flush.

Reset
REQ-034 While rst_n=0, pointers, level and the timeout counter SHALL be 0; empty=1, full=0, level=0, and overrun, frame_err, thresh_irq, timeout_irq and rd_perr SHALL all be 0.
REQ-035 rd_data SHALL be 0 during reset; storage array contents SHALL NOT be reset.
REQ-036 Reset asserted mid-operation SHALL discard all entries immediately; the first push after release SHALL land at entry 0.

Verification
REQ-037 Push 0x11,0x22,0x33 then pop 3 -> rd_data sequence 0x11,0x22,0x33, level 3->0, empty=1 at end.
REQ-038 Push 17 characters with DEPTH=16 and no pops -> full=1, level=16, overrun=1, the 17th character lost; then clr_status -> overrun=0.
REQ-039 With full=1, push 0xAA and rd_en in the same cycle -> level stays 16, overrun=0, 0xAA read last.
REQ-040 rx_ready=1 with rx_error=1 and data 0x5A -> entry stored with rd_perr=1; rx_error pulse alone -> frame_err=1, level unchanged.
REQ-041 One entry held with no activity -> timeout_irq=1 after 704 baud ticks; a pop clears it and empty=1.
REQ-042 Push 8 entries -> thresh_irq=1 at level 8; flush together with rd_en -> level=0, all flags 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive FIFO with first-word fall-through read, sticky
//               overrun/framing status, fill-level and idle-timeout interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int THRESH        = 8,
  parameter int TIMEOUT_TICKS = 704
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       baud_en_16x,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       rx_ready,
  input  logic                       rx_error,
  input  logic                       rd_en,
  input  logic                       flush,
  input  logic                       clr_status,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_perr,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic                       frame_err,
  output logic                       thresh_irq,
  output logic                       timeout_irq
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [c_LW-1:0] c_FULL_LVL   = c_LW'(DEPTH);
  localparam logic [c_LW-1:0] c_THRESH_LVL = c_LW'(THRESH);
  localparam logic [c_TW-1:0] c_TO_MAX     = c_TW'(TIMEOUT_TICKS);

  // Each entry carries the parity-error flag above the character bits.
  logic [DATA_WIDTH:0] r_mem [DEPTH];

  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic [c_LW-1:0] w_level_nxt;
  logic [c_TW-1:0] r_tcnt;
  logic            r_overrun;
  logic            r_frame_err;
  logic            r_thresh;
  logic            r_timeout;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_ovr_set;
  logic            w_frm_set;
  logic [DATA_WIDTH:0] w_head;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == c_FULL_LVL);
  assign w_pop     = rd_en && !w_empty && !flush;
  // A full FIFO still accepts a character when a pop frees a slot in the same cycle.
  assign w_push    = rx_ready && (!w_full || w_pop) && !flush;
  assign w_ovr_set = rx_ready && w_full && !w_pop;
  assign w_frm_set = rx_error && !rx_ready;

  always_comb begin
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_level_nxt = r_level + c_LW'(1);
        2'b01:   w_level_nxt = r_level - c_LW'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {rx_error, rx_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_thresh <= 1'b0;
    end else begin
      r_level  <= w_level_nxt;
      r_thresh <= (w_level_nxt >= c_THRESH_LVL);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
    end
  end

  // Sticky status: a set event beats clr_status, flush beats everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (flush) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)       r_overrun   <= 1'b1;
      else if (clr_status) r_overrun   <= 1'b0;
      if (w_frm_set)       r_frame_err <= 1'b1;
      else if (clr_status) r_frame_err <= 1'b0;
    end
  end

  // Idle timeout: any arriving character or successful pop counts as activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (flush) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (rx_ready || w_pop || w_empty) begin
        r_tcnt <= '0;
      end else if (baud_en_16x && (r_tcnt != c_TO_MAX)) begin
        r_tcnt <= r_tcnt + c_TW'(1);
      end
      if (rx_ready || w_pop) begin
        r_timeout <= 1'b0;
      end else if (r_tcnt == c_TO_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign rd_data     = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign rd_perr     = w_empty ? 1'b0 : w_head[DATA_WIDTH];
  assign empty       = w_empty;
  assign full        = w_full;
  assign level       = r_level;
  assign overrun     = r_overrun;
  assign frame_err   = r_frame_err;
  assign thresh_irq  = r_thresh;
  assign timeout_irq = r_timeout;

endmodule
`default_nettype wire
